// File: rtl/riscv_next_ret_table_ctrl.sv
// Write-port sequencer for the return-hit table: arbitrates fetch/execute pushes
// with fetch starvation protection and runs a one-entry-per-cycle invalidate sweep.
module riscv_next_ret_table_ctrl #(
   parameter int ADDR_WIDTH   = 64,
   parameter int INDEX_WIDTH  = 3,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  enable,
   input  logic                  i_stall,
   input  logic                  i_fe_req,
   input  logic [ADDR_WIDTH-1:0] i_fe_addr,
   output logic                  o_fe_ack,
   input  logic                  i_ex_req,
   input  logic [ADDR_WIDTH-1:0] i_ex_addr,
   output logic                  o_ex_ack,
   input  logic                  i_flush,
   output logic                  o_flush_busy,
   output logic                  o_tbl_wr_en,
   output logic [ADDR_WIDTH-1:0] o_tbl_wr_addr,
   output logic                  o_tbl_wr_valid
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SWEEP = 1'b1;
   localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic [0:0]             state_reg;
   logic [INDEX_WIDTH-1:0] index_reg;
   logic [3:0]             starve_reg;
   logic                   frozen;
   logic                   arb_ok;
   logic                   fe_win;
   logic                   ex_win;

   always_comb begin
      frozen = !enable || i_stall;
      // Grants only in an unfrozen IDLE cycle that is not starting a sweep.
      arb_ok = nreset && !frozen && (state_reg == ST_IDLE) && !i_flush;
      fe_win = 1'b0;
      ex_win = 1'b0;
      if (arb_ok) begin
         if (i_fe_req && i_ex_req) begin
            if (starve_reg >= STARVE_MAX)
               fe_win = 1'b1;
            else
               ex_win = 1'b1;
         end else if (i_fe_req) begin
            fe_win = 1'b1;
         end else if (i_ex_req) begin
            ex_win = 1'b1;
         end
      end
   end

   assign o_fe_ack     = fe_win;
   assign o_ex_ack     = ex_win;
   assign o_flush_busy = state_reg;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_reg      <= ST_IDLE;
         index_reg      <= '0;
         starve_reg     <= '0;
         o_tbl_wr_en    <= 1'b0;
         o_tbl_wr_addr  <= '0;
         o_tbl_wr_valid <= 1'b0;
      end else begin
         o_tbl_wr_en <= 1'b0;
         if (!frozen) begin
            if (state_reg == ST_SWEEP) begin
               // The current entry is invalidated even when a restart arrives.
               o_tbl_wr_en    <= 1'b1;
               o_tbl_wr_valid <= 1'b0;
               o_tbl_wr_addr  <= {{(ADDR_WIDTH-INDEX_WIDTH){1'b0}}, index_reg};
               if (i_flush) begin
                  index_reg <= '0;
               end else begin
                  index_reg <= index_reg + 1'b1;
                  if (index_reg == LAST_INDEX)
                     state_reg <= ST_IDLE;
               end
            end else if (i_flush) begin
               state_reg <= ST_SWEEP;
               index_reg <= '0;
            end else if (fe_win) begin
               o_tbl_wr_en    <= 1'b1;
               o_tbl_wr_valid <= 1'b1;
               o_tbl_wr_addr  <= i_fe_addr;
               starve_reg     <= '0;
            end else if (ex_win) begin
               o_tbl_wr_en    <= 1'b1;
               o_tbl_wr_valid <= 1'b1;
               o_tbl_wr_addr  <= i_ex_addr;
               if (i_fe_req)
                  starve_reg <= starve_reg + 1'b1;
            end
         end
      end
   end

endmodule
